// File: rtl/alu_seq_if.sv
// Handshake and operand bus between the execute stage and the registered ALU.
// The master offers operations and consumes results; the slave is alu_seq.
interface alu_seq_if #(
  parameter int DATA_WID = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [2:0]          ALUfun;
  logic [DATA_WID-1:0] ALUA;
  logic [DATA_WID-1:0] ALUB;
  logic                set_cond;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_WID-1:0] valE;
  logic [3:0]          CC;

  modport master (
    output in_valid, ALUfun, ALUA, ALUB, set_cond, flush, out_ready,
    input  in_ready, out_valid, valE, CC
  );

  modport slave (
    input  in_valid, ALUfun, ALUA, ALUB, set_cond, flush, out_ready,
    output in_ready, out_valid, valE, CC
  );
endinterface

// File: rtl/alu_seq.sv
// Registered execute ALU with valid/ready handshake on both sides.
// Operand order is always valB op valA. Single-cycle ops complete at the
// accept edge; MUL runs one shift-add step per cycle for DATA_WID cycles.
// Condition codes live here: CC = {CF, OF, SF, ZF}.
module alu_seq #(
  parameter int DATA_WID = 32,
  parameter int MUL_EN   = 1
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(DATA_WID);
  localparam int CW  = $clog2(DATA_WID) + 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t                state;
  logic                  out_valid;
  logic [DATA_WID-1:0]   val_e;
  logic [3:0]            cc;
  logic                  cond_q;
  logic [CW-1:0]         cnt;

  logic [2*DATA_WID-1:0] mul_cand;
  logic [2*DATA_WID-1:0] mul_acc;
  logic [DATA_WID-1:0]   mul_plier;
  logic [2*DATA_WID-1:0] acc_next;

  logic                  in_ready;
  logic                  accept;
  logic                  start_mul;
  logic [DATA_WID+3:0]   calc;
  logic [DATA_WID+3:0]   mul_fin;

  // Single-cycle result and flags, packed as {CF, OF, SF, ZF, result}.
  function automatic logic [DATA_WID+3:0] alu_op(
    input logic [2:0]          fun,
    input logic [DATA_WID-1:0] a,
    input logic [DATA_WID-1:0] b
  );
    logic signed [DATA_WID-1:0] sa;
    logic signed [DATA_WID-1:0] sb;
    logic signed [DATA_WID-1:0] sr;
    logic [DATA_WID:0]          wide;
    logic [DATA_WID-1:0]        r;
    logic [SHW-1:0]             amt;
    logic                       cf;
    logic                       of;
    sa   = $signed(a);
    sb   = $signed(b);
    amt  = a[SHW-1:0];
    wide = '0;
    r    = '0;
    cf   = 1'b0;
    of   = 1'b0;
    case (fun)
      OP_ADD: begin
        wide = {1'b0, b} + {1'b0, a};
        r    = wide[DATA_WID-1:0];
        sr   = $signed(r);
        cf   = wide[DATA_WID];
        of   = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sb < 0));
      end
      OP_SUB: begin
        r  = b - a;
        sr = $signed(r);
        cf = (b < a);
        of = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sb < 0));
      end
      OP_AND: r = b & a;
      OP_OR:  r = b | a;
      OP_XOR: r = b ^ a;
      // The extra bit above/below the value catches the last bit shifted out;
      // it stays 0 for a zero shift amount.
      OP_SHL: begin
        wide = {1'b0, b} << amt;
        r    = wide[DATA_WID-1:0];
        cf   = wide[DATA_WID];
      end
      OP_SHR: begin
        wide = {b, 1'b0} >> amt;
        r    = wide[DATA_WID:1];
        cf   = wide[0];
      end
      default: r = '0;
    endcase
    return {cf, of, r[DATA_WID-1], ~|r, r};
  endfunction

  // MUL result and flags from the full product: CF=OF flag a nonzero high half.
  function automatic logic [DATA_WID+3:0] mul_flags(input logic [2*DATA_WID-1:0] p);
    logic hi;
    hi = |p[2*DATA_WID-1:DATA_WID];
    return {hi, hi, p[DATA_WID-1], ~|p[DATA_WID-1:0], p[DATA_WID-1:0]};
  endfunction

  assign in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept    = bus.in_valid && in_ready && !bus.flush;
  assign start_mul = (MUL_EN != 0) && (bus.ALUfun == OP_MUL);
  assign calc      = alu_op(bus.ALUfun, bus.ALUA, bus.ALUB);
  assign acc_next  = mul_acc + (mul_plier[0] ? mul_cand : '0);
  assign mul_fin   = mul_flags(acc_next);

  // Control FSM: state, output valid, result register and condition codes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      val_e     <= '0;
      cc        <= 4'b0000;
      cond_q    <= 1'b0;
      cnt       <= '0;
    end else if (bus.flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else if (accept) begin
      cond_q <= bus.set_cond;
      cnt    <= '0;
      if (start_mul) begin
        state     <= MUL;
        out_valid <= 1'b0;
      end else begin
        state     <= DONE;
        out_valid <= 1'b1;
        val_e     <= calc[DATA_WID-1:0];
        if (bus.set_cond) cc <= calc[DATA_WID+3:DATA_WID];
      end
    end else begin
      case (state)
        MUL: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DATA_WID - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            val_e     <= mul_fin[DATA_WID-1:0];
            if (cond_q) cc <= mul_fin[DATA_WID+3:DATA_WID];
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Shift-add multiplier datapath: loaded at accept, one step per MUL cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      mul_cand  <= {{DATA_WID{1'b0}}, bus.ALUB};
      mul_plier <= bus.ALUA;
      mul_acc   <= '0;
    end else if (state == MUL) begin
      mul_cand  <= mul_cand << 1;
      mul_plier <= mul_plier >> 1;
      mul_acc   <= acc_next;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.valE      = val_e;
  assign bus.CC        = cc;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at DATA_WID=8 with the iterative multiplier.
// CC expectations are written as {CF, OF, SF, ZF}.
module tb_alu_seq;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_seq_if #(.DATA_WID(8)) bus ();

  alu_seq #(.DATA_WID(8), .MUL_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one op and let the next rising edge accept it.
  task automatic issue(input logic [2:0] f, input logic [7:0] b, input logic [7:0] a,
                       input logic sc);
    bus.in_valid = 1'b1;
    bus.ALUfun   = f;
    bus.ALUB     = b;
    bus.ALUA     = a;
    bus.set_cond = sc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.valE !== 8'h00) begin bad++; $display("FAIL rst_valE: got %h want 00", bus.valE); end
    total++; if (bus.CC !== 4'b0000) begin bad++; $display("FAIL rst_CC: got %b want 0000", bus.CC); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL idle_out_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_add_sub();
    issue(3'd0, 8'h7F, 8'h01, 1'b1);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL add_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.valE !== 8'h80) begin bad++; $display("FAIL add_valE: got %h want 80", bus.valE); end
    total++; if (bus.CC !== 4'b0110) begin bad++; $display("FAIL add_CC: got %b want 0110", bus.CC); end
    issue(3'd1, 8'h03, 8'h05, 1'b1);
    total++; if (bus.valE !== 8'hFE) begin bad++; $display("FAIL sub_valE: got %h want FE", bus.valE); end
    total++; if (bus.CC !== 4'b1010) begin bad++; $display("FAIL sub_CC: got %b want 1010", bus.CC); end
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL sub_retire: got %b want 0", bus.out_valid); end
  endtask

  task automatic run_mul(input logic [7:0] b, input logic [7:0] a,
                         input logic [7:0] exp_v, input logic [3:0] exp_cc);
    issue(3'd7, b, a, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        bad++; $display("FAIL mul_busy: cycle %0d got rdy=%b vld=%b want 0 0", i, bus.in_ready, bus.out_valid);
      end
      @(posedge clk); #1;
    end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mul_done: got %b want 1", bus.out_valid); end
    total++; if (bus.valE !== exp_v) begin bad++; $display("FAIL mul_valE: got %h want %h", bus.valE, exp_v); end
    total++; if (bus.CC !== exp_cc) begin bad++; $display("FAIL mul_CC: got %b want %b", bus.CC, exp_cc); end
  endtask

  task automatic test_mul();
    run_mul(8'h10, 8'h11, 8'h10, 4'b1100);
    run_mul(8'h03, 8'h05, 8'h0F, 4'b0000);
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mul_retire: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] f  [5] = '{3'd0, 3'd2, 3'd5, 3'd6, 3'd5};
    logic [7:0] b  [5] = '{8'h01, 8'hF0, 8'h81, 8'h81, 8'h80};
    logic [7:0] a  [5] = '{8'h02, 8'h3C, 8'h01, 8'h09, 8'h08};
    logic [7:0] ev [5] = '{8'h03, 8'h30, 8'h02, 8'h40, 8'h80};
    logic [3:0] ec [5] = '{4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0010};
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: op %0d got %b want 1", i, bus.in_ready); end
      issue(f[i], b[i], a[i], 1'b1);
      total++;
      if (bus.out_valid !== 1'b1 || bus.valE !== ev[i] || bus.CC !== ec[i]) begin
        bad++; $display("FAIL b2b_result: op %0d got v=%b %h cc=%b want 1 %h %b", i, bus.out_valid, bus.valE, bus.CC, ev[i], ec[i]);
      end
      if (i < 4) bus.in_valid = 1'b1;
    end
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_retire: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_hold();
    bus.out_ready = 1'b0;
    issue(3'd3, 8'h50, 8'h0A, 1'b1);
    bus.in_valid = 1'b1;
    bus.ALUfun   = 3'd0;
    bus.ALUB     = 8'hFF;
    bus.ALUA     = 8'h01;
    bus.set_cond = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.valE !== 8'h5A || bus.CC !== 4'b0000) begin
        bad++; $display("FAIL hold_stable: cycle %0d got rdy=%b vld=%b %h cc=%b want 0 1 5a 0000", i, bus.in_ready, bus.out_valid, bus.valE, bus.CC);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL hold_release_ready: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.valE !== 8'h00 || bus.CC !== 4'b1001) begin
      bad++; $display("FAIL hold_next_op: got vld=%b %h cc=%b want 1 00 1001", bus.out_valid, bus.valE, bus.CC);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_no_cond();
    issue(3'd4, 8'hFF, 8'hFF, 1'b0);
    total++; if (bus.valE !== 8'h00) begin bad++; $display("FAIL nocond_valE: got %h want 00", bus.valE); end
    total++; if (bus.CC !== 4'b1001) begin bad++; $display("FAIL nocond_CC: got %b want 1001", bus.CC); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    logic seen;
    issue(3'd1, 8'h01, 8'h02, 1'b1);
    total++; if (bus.valE !== 8'hFF || bus.CC !== 4'b1010) begin bad++; $display("FAIL flush_pre: got %h %b want ff 1010", bus.valE, bus.CC); end
    @(posedge clk); #1;
    issue(3'd7, 8'hFF, 8'hFF, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_idle: got rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid); end
    total++; if (bus.valE !== 8'hFF || bus.CC !== 4'b1010) begin bad++; $display("FAIL flush_keep: got %h %b want ff 1010", bus.valE, bus.CC); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_valid: got %b want 0", seen); end
    // Flush wins over a same-cycle offer.
    bus.flush = 1'b1;
    issue(3'd0, 8'h7F, 8'h01, 1'b1);
    bus.flush = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.valE !== 8'hFF) begin bad++; $display("FAIL flush_prio: got vld=%b %h want 0 ff", bus.out_valid, bus.valE); end
    issue(3'd0, 8'h02, 8'h03, 1'b1);
    total++; if (bus.out_valid !== 1'b1 || bus.valE !== 8'h05 || bus.CC !== 4'b0000) begin bad++; $display("FAIL flush_after_add: got vld=%b %h %b want 1 05 0000", bus.out_valid, bus.valE, bus.CC); end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid_mul();
    logic seen;
    issue(3'd7, 8'hFF, 8'hFF, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmul_ctrl: got vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready); end
    total++; if (bus.valE !== 8'h00 || bus.CC !== 4'b0000) begin bad++; $display("FAIL rstmul_data: got %h %b want 00 0000", bus.valE, bus.CC); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmul_no_valid: got %b want 0", seen); end
    issue(3'd0, 8'h7F, 8'h01, 1'b1);
    total++; if (bus.out_valid !== 1'b1 || bus.valE !== 8'h80 || bus.CC !== 4'b0110) begin bad++; $display("FAIL rstmul_after_add: got vld=%b %h %b want 1 80 0110", bus.out_valid, bus.valE, bus.CC); end
    @(posedge clk); #1;
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.ALUfun    = 3'd0;
    bus.ALUA      = 8'h00;
    bus.ALUB      = 8'h00;
    bus.set_cond  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_add_sub();
    test_mul();
    test_back_to_back();
    test_hold();
    test_no_cond();
    test_flush();
    test_rst_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle execute ALU.
- Adds XOR, logical shifts and an iterative multiplier, and keeps the condition codes in a register inside the block.
- Uses a valid/ready handshake on both sides, so the execute stage can stall on the multi-cycle multiply.
- Operand order is always valB op valA (SUB is ALUB - ALUA).

Parameters:
- DATA_WID, 32, operand/result width; must be a power of two and at least 8.
- MUL_EN, 1, 1 = iterative MUL implemented; 0 = MUL opcode returns 0 in one cycle with CC ZF=1, others 0.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  block accepts this cycle.
- ALUfun  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 MUL.
- ALUA  in  DATA_WID  operand A.
- ALUB  in  DATA_WID  operand B.
- set_cond  in  1  update CC when this op completes.
- flush  in  1  synchronous abort of the in-flight op.
- out_valid  out  1  valE holds a result.
- out_ready  in  1  consumer takes the result.
- valE  out  DATA_WID  registered result.
- CC  out  4  registered flags: [0] ZF, [1] SF, [2] OF, [3] CF.

Behaviour:
- Reset values: state IDLE; valE=0; CC=4'b0000; out_valid=0; in_ready=1.
- States:
  - IDLE: in_ready=1.
  - MUL: busy, in_ready=0.
  - DONE: out_valid=1, in_ready=out_ready.
- Acceptance: an op is accepted at a rising edge when in_valid && in_ready. The inputs ALUfun, ALUA, ALUB and set_cond are latched at that edge.
- Single-cycle ops (0-6, or 7 with MUL_EN=0): result is loaded into valE at the accept edge; state goes to DONE. out_valid is high from the next cycle, so latency is 1.
- MUL: the accept edge loads an internal multiplicand, multiplier and accumulator and enters MUL. The block does one shift-add step per cycle for DATA_WID cycles; valE is loaded and DONE entered at the DATA_WID-th edge after accept.
- valE for MUL is the low DATA_WID bits of ALUB*ALUA (unsigned).
- Shifts: amount = ALUA[$clog2(DATA_WID)-1:0]; upper bits of ALUA are ignored. Value shifted is ALUB.
- DONE handshake:
  - out_valid && out_ready retires the result.
  - If in_valid at the same edge, the new op is accepted back-to-back (full throughput for single-cycle ops).
  - Otherwise the state returns to IDLE.
  - Without out_ready, valE/out_valid hold stable.
- CC:
  - Written only at the edge that loads valE, and only if the latched set_cond=1; otherwise held.
  - ZF = valE==0; SF = valE MSB.
  - ADD: CF = unsigned carry-out; OF = operands same sign and result sign differs.
  - SUB: CF = unsigned borrow (ALUB<ALUA); OF = ALUB and ALUA differ in sign and result sign differs from ALUB.
  - AND/OR/XOR: OF=CF=0.
  - SHL/SHR: CF = last bit shifted out (0 if amount 0); OF=0.
  - MUL: CF=OF = high half of full product nonzero.
- flush:
  - In any state, state returns to IDLE at the next edge; out_valid=0; valE and CC are unchanged.
  - flush has priority over acceptance and completion in the same cycle: no op is accepted and a completing MUL does not write.
- rst mid-MUL: immediate return to reset values; the partial product is discarded.
- Combinational paths: in_ready depends on out_ready only in DONE; no path from in_valid to out_valid.

Test Plan (DATA_WID=8):
- ADD 8'h7F+8'h01, set_cond=1 -> one cycle later out_valid=1, valE=8'h80, CC ZF=0 SF=1 OF=1 CF=0; then SUB ALUB=8'h03 ALUA=8'h05 -> valE=8'hFE, SF=1, CF=1, OF=0.
- MUL ALUB=8'h10 ALUA=8'h11, set_cond=1 -> in_ready low for 8 cycles, out_valid on the 8th edge after accept, valE=8'h10, CF=OF=1; 8'h03*8'h05 -> 8'h0F, CF=OF=0.
- Back-to-back ADD, AND, SHL streamed with out_ready=1 -> one result per cycle. SHL 8'h81 by 1 -> valE=8'h02, CF=1. SHR with ALUA=8'h09 shifts by 1, not 9.
- out_ready held low 3 cycles in DONE -> valE/out_valid stable and in_ready=0; release -> retire, next op accepted the same edge.
- set_cond=0 XOR 8'hFF^8'hFF -> valE=0, CC unchanged from the previous op.
- flush at cycle 4 of MUL, plus a rst pulse mid-MUL in a separate run -> IDLE, out_valid never asserts, CC/valE unchanged (flush) or zeroed (rst); the next ADD works normally.
